// File: rtl/bitstream_field_scheduler_pkg.sv
// Shared types and constants for the bitstream field scheduler: FSM states and source indices.
package bitstream_pkg;

  localparam int DATA_W_DEFAULT = 64;
  localparam int NUM_SRC        = 4;

  localparam int SRC_FRAME_HDR  = 0;
  localparam int SRC_PIC_HDR    = 1;
  localparam int SRC_SLICE_HDR  = 2;
  localparam int SRC_SLICE_DATA = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_HDR,
    ST_PIC_HDR,
    ST_SLICE_HDR,
    ST_SLICE_DATA,
    ST_FLUSH,
    ST_DONE
  } state_t;

  function automatic logic is_phase(state_t s);
    return (s == ST_FRAME_HDR) || (s == ST_PIC_HDR) ||
           (s == ST_SLICE_HDR) || (s == ST_SLICE_DATA);
  endfunction

  function automatic logic [1:0] src_of_state(state_t s);
    case (s)
      ST_PIC_HDR:    return 2'(SRC_PIC_HDR);
      ST_SLICE_HDR:  return 2'(SRC_SLICE_HDR);
      ST_SLICE_DATA: return 2'(SRC_SLICE_DATA);
      default:       return 2'(SRC_FRAME_HDR);
    endcase
  endfunction

endpackage

// File: rtl/bitstream_field_scheduler_if.sv
// Frame control, per-source field streams and bit-packer output of the field scheduler.
interface bitstream_field_scheduler_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic                frame_start;
  logic [CNT_W-1:0]    slice_count;
  logic                frame_busy;
  logic                frame_done;
  logic [3:0]          src_start;
  logic [3:0]          src_done;
  logic [3:0]          src_enable;
  logic [4*DATA_W-1:0] src_val;
  logic [4*DATA_W-1:0] src_size;
  logic [3:0]          src_flush;
  logic                output_enable;
  logic [DATA_W-1:0]   val;
  logic [DATA_W-1:0]   size_of_bit;
  logic                flush_bit;
  logic [31:0]         field_count;
  logic                protocol_error;

  modport master (
    output frame_start, slice_count, src_done, src_enable, src_val, src_size, src_flush,
    input  frame_busy, frame_done, src_start, output_enable, val, size_of_bit, flush_bit,
           field_count, protocol_error
  );

  modport slave (
    input  frame_start, slice_count, src_done, src_enable, src_val, src_size, src_flush,
    output frame_busy, frame_done, src_start, output_enable, val, size_of_bit, flush_bit,
           field_count, protocol_error
  );
endinterface

// File: rtl/bitstream_field_scheduler_field_mux.sv
// Registered 4:1 field selector with flush-field injection; one cycle latency, no backpressure.
module field_mux
  import bitstream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sel_en,
  input  logic [1:0]                sel,
  input  logic                      inject_flush,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [NUM_SRC*DATA_W-1:0] src_val,
  input  logic [NUM_SRC*DATA_W-1:0] src_size,
  input  logic [NUM_SRC-1:0]        src_flush,
  output logic                      output_enable,
  output logic [DATA_W-1:0]         val,
  output logic [DATA_W-1:0]         size_of_bit,
  output logic                      flush_bit
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      output_enable <= 1'b0;
      val           <= '0;
      size_of_bit   <= '0;
      flush_bit     <= 1'b0;
    end else if (inject_flush) begin
      output_enable <= 1'b1;
      val           <= '0;
      size_of_bit   <= '0;
      flush_bit     <= 1'b1;
    end else if (sel_en && src_enable[sel]) begin
      output_enable <= 1'b1;
      val           <= src_val[int'(sel)*DATA_W +: DATA_W];
      size_of_bit   <= src_size[int'(sel)*DATA_W +: DATA_W];
      flush_bit     <= src_flush[sel];
    end else begin
      output_enable <= 1'b0;
      val           <= '0;
      size_of_bit   <= '0;
      flush_bit     <= 1'b0;
    end
  end

endmodule

// File: rtl/bitstream_field_scheduler.sv
// Frame sequencer: runs frame/picture/slice header and slice data sources in order, forwards the
// granted source's fields with one cycle latency, then closes the frame with a flush field.
module bitstream_field_scheduler
  import bitstream_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  bitstream_field_scheduler_if.slave bus
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     slices_left;
  logic [WD_W-1:0]      wd_cnt;
  logic [NUM_SRC-1:0]   src_start_q;
  logic [31:0]          field_count_q;
  logic                 protocol_error_q;

  logic                 in_phase;
  logic [1:0]           cur_src;
  logic [NUM_SRC-1:0]   active_mask;
  logic                 cur_done;
  logic                 field_load;
  logic                 stray;
  logic                 wd_expired;
  logic                 frame_accept;
  logic                 enter_phase;

  logic                 mux_oe;
  logic [DATA_W-1:0]    mux_val;
  logic [DATA_W-1:0]    mux_size;
  logic                 mux_flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    in_phase     = is_phase(state);
    cur_src      = src_of_state(state);
    active_mask  = in_phase ? (NUM_SRC'(1) << cur_src) : '0;
    cur_done     = |(bus.src_done & active_mask);
    field_load   = (|(bus.src_enable & active_mask)) || (state == ST_FLUSH);
    // Anything from a source that does not own the current phase is a protocol violation.
    stray        = |((bus.src_done | bus.src_enable) & ~active_mask);
    wd_expired   = in_phase && !cur_done && (wd_cnt == WD_W'(TIMEOUT - 1));
    frame_accept = 1'b0;
    state_nxt    = state;
    case (state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          frame_accept = 1'b1;
          state_nxt    = ST_FRAME_HDR;
        end
      end
      ST_FRAME_HDR:  if (cur_done) state_nxt = ST_PIC_HDR;
      ST_PIC_HDR:    if (cur_done) state_nxt = ST_SLICE_HDR;
      ST_SLICE_HDR:  if (cur_done) state_nxt = ST_SLICE_DATA;
      ST_SLICE_DATA: begin
        if (cur_done) state_nxt = (slices_left > CNT_W'(1)) ? ST_SLICE_HDR : ST_FLUSH;
      end
      ST_FLUSH:      state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
    if (wd_expired) state_nxt = ST_FLUSH;
    enter_phase = is_phase(state_nxt) && (state_nxt != state);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slices_left      <= '0;
      wd_cnt           <= '0;
      src_start_q      <= '0;
      field_count_q    <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      src_start_q <= enter_phase ? (NUM_SRC'(1) << src_of_state(state_nxt)) : '0;

      if (frame_accept)
        slices_left <= (bus.slice_count == '0) ? CNT_W'(1) : bus.slice_count;
      else if (state == ST_SLICE_DATA && cur_done)
        slices_left <= slices_left - CNT_W'(1);

      if (state_nxt != state) wd_cnt <= '0;
      else if (in_phase)      wd_cnt <= wd_cnt + WD_W'(1);

      if (frame_accept)
        field_count_q <= '0;
      else if (field_load && field_count_q != 32'hFFFF_FFFF)
        field_count_q <= field_count_q + 32'd1;

      if (frame_accept)             protocol_error_q <= 1'b0;
      else if (stray || wd_expired) protocol_error_q <= 1'b1;
    end
  end

  field_mux #(.DATA_W(DATA_W)) u_field_mux (
    .clock         (clock),
    .reset         (reset),
    .sel_en        (in_phase),
    .sel           (cur_src),
    .inject_flush  (state == ST_FLUSH),
    .src_enable    (bus.src_enable),
    .src_val       (bus.src_val),
    .src_size      (bus.src_size),
    .src_flush     (bus.src_flush),
    .output_enable (mux_oe),
    .val           (mux_val),
    .size_of_bit   (mux_size),
    .flush_bit     (mux_flush)
  );

  assign bus.output_enable  = mux_oe;
  assign bus.val            = mux_val;
  assign bus.size_of_bit    = mux_size;
  assign bus.flush_bit      = mux_flush;
  assign bus.src_start      = src_start_q;
  assign bus.frame_busy     = (state != ST_IDLE);
  assign bus.frame_done     = (state == ST_DONE);
  assign bus.field_count    = field_count_q;
  assign bus.protocol_error = protocol_error_q;

endmodule

// File: tb/tb_bitstream_field_scheduler.sv
// Randomized bench: scripted sources answer each start pulse; a queue model holds the fields each frame must emit.
`timescale 1ns/1ps
module tb_bitstream_field_scheduler;
  import bitstream_pkg::*;

  localparam int DW = 64;
  localparam int CW = 16;
  localparam int TO = 16;

  typedef struct { logic en; logic dn; logic f; logic [63:0] v; logic [63:0] s; } act_t;
  typedef struct { logic [63:0] v; logic [63:0] s; logic f; int c; } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bitstream_field_scheduler_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  bitstream_field_scheduler #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  act_t plan[$];
  exp_t expq[$];
  int   cur_src, prev_src, flush_seen, done_seen, exp_fields, busy_drop, s3_cyc, done_cyc;
  int   starts[4];
  bit   directed, stray_mode, stuck_mode, mid_mode, stray_done, mid_done, in_frame, busy_up;
  logic [63:0] pic_v[7];
  logic [63:0] pic_s[7];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic init_vars();
    plan.delete();
    expq.delete();
    cur_src = -1; prev_src = -1;
    starts = '{default: 0};
    flush_seen = 0; done_seen = 0; exp_fields = 0; busy_drop = 0; s3_cyc = 0; done_cyc = 0;
    stray_done = 1'b0; mid_done = 1'b0; in_frame = 1'b0; busy_up = 1'b0;
  endtask

  // Each source emits a few fields (optionally with idle gaps) and a done pulse, well inside the watchdog window.
  task automatic gen_plan(input int i);
    int nf;
    bit dl;
    act_t a;
    plan.delete();
    if (directed) nf = (i == SRC_FRAME_HDR) ? 2 : (i == SRC_PIC_HDR) ? 7 : (i == SRC_SLICE_HDR) ? 1 : 3;
    else          nf = $urandom_range(0, 4);
    dl = (nf > 0) && (directed || ($urandom_range(0, 1) == 1)) && !(stuck_mode && i == SRC_SLICE_DATA);
    for (int k = 0; k < nf; k++) begin
      if (!directed && $urandom_range(0, 2) == 0) begin
        a = '{en: 1'b0, dn: 1'b0, f: 1'b0, v: 64'd0, s: 64'd0};
        plan.push_back(a);
      end
      a.en = 1'b1;
      a.dn = dl && (k == nf - 1);
      a.f  = directed ? 1'b0 : ($urandom_range(0, 5) == 0);
      if (directed && i == SRC_PIC_HDR) begin
        a.v = pic_v[k];
        a.s = pic_s[k];
      end else begin
        a.v = {$urandom, $urandom};
        a.s = 64'($urandom_range(1, 64));
      end
      plan.push_back(a);
    end
    if (!dl && !(stuck_mode && i == SRC_SLICE_DATA)) begin
      a = '{en: 1'b0, dn: 1'b1, f: 1'b0, v: 64'd0, s: 64'd0};
      plan.push_back(a);
    end
  endtask

  // One cycle: observe outputs at the falling edge, then drive the active source for the next rising edge.
  task automatic step();
    act_t a;
    exp_t e;
    bit   found;
    int   exp_prev;
    @(negedge clock);
    if (bus.output_enable) begin
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("field_cycle", cyc, e.c);
        check("field_val", bus.val, e.v);
        check("field_size", bus.size_of_bit, e.s);
        check("field_flush", bus.flush_bit, e.f);
      end else begin
        check("flush_field_bit", bus.flush_bit, 1);
        check("flush_field_val", bus.val, 0);
        check("flush_field_size", bus.size_of_bit, 0);
        flush_seen++;
      end
    end
    if (bus.src_start != 4'd0) begin
      check("start_onehot", $countones(bus.src_start), 1);
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (bus.src_start[i] && !found) begin
          found = 1'b1;
          exp_prev = (i == SRC_FRAME_HDR) ? -1 :
                     (i == SRC_SLICE_HDR && starts[SRC_SLICE_HDR] > 0) ? SRC_SLICE_DATA : i - 1;
          check("start_order", prev_src, exp_prev);
          prev_src = i;
          starts[i]++;
          cur_src = i;
          if (i == SRC_SLICE_DATA) s3_cyc = cyc;
          gen_plan(i);
        end
      end
    end
    if (in_frame) begin
      if (bus.frame_busy)  busy_up = 1'b1;
      else if (busy_up)    busy_drop++;
    end
    if (bus.frame_done) begin
      if (done_seen == 0) done_cyc = cyc;
      done_seen++;
    end

    bus.frame_start = 1'b0;
    bus.src_enable  = '0;
    bus.src_done    = '0;
    bus.src_flush   = '0;
    bus.src_val     = '0;
    bus.src_size    = '0;
    if (cur_src >= 0 && plan.size() > 0) begin
      a = plan.pop_front();
      bus.src_enable[cur_src]          = a.en;
      bus.src_done[cur_src]            = a.dn;
      bus.src_flush[cur_src]           = a.f;
      bus.src_val[cur_src*DW +: DW]    = a.v;
      bus.src_size[cur_src*DW +: DW]   = a.s;
      if (a.en) begin
        e = '{v: a.v, s: a.s, f: a.f, c: cyc + 1};
        expq.push_back(e);
        exp_fields++;
      end
    end
    if (stray_mode && cur_src == SRC_FRAME_HDR && !stray_done) begin
      bus.src_enable[SRC_PIC_HDR]     = 1'b1;
      bus.src_val[SRC_PIC_HDR*DW +: DW] = 64'hDEAD_BEEF;
      bus.src_size[SRC_PIC_HDR*DW +: DW] = 64'd32;
      stray_done = 1'b1;
    end
    if (mid_mode && cur_src == SRC_PIC_HDR && !mid_done) begin
      bus.frame_start = 1'b1;
      mid_done = 1'b1;
    end
  endtask

  task automatic run_frame(input int sc, input bit dir, input bit stray, input bit stuck,
                           input bit mid, input logic perr_exp);
    int n_sl;
    int budget;
    init_vars();
    directed = dir; stray_mode = stray; stuck_mode = stuck; mid_mode = mid;
    n_sl = stuck ? 1 : ((sc == 0) ? 1 : sc);
    step();
    bus.frame_start = 1'b1;
    bus.slice_count = CW'(sc);
    in_frame = 1'b1;
    budget = 0;
    while (done_seen == 0 && budget < 1000) begin
      step();
      budget++;
    end
    check("frame_done_seen", done_seen, 1);
    check("busy_at_done", bus.frame_busy, 1);
    check("field_count", bus.field_count, exp_fields + 1);
    check("flush_fields", flush_seen, 1);
    check("fields_missing", expq.size(), 0);
    check("starts_frame_hdr", starts[SRC_FRAME_HDR], 1);
    check("starts_pic_hdr", starts[SRC_PIC_HDR], 1);
    check("starts_slice_hdr", starts[SRC_SLICE_HDR], n_sl);
    check("starts_slice_data", starts[SRC_SLICE_DATA], n_sl);
    check("protocol_error", bus.protocol_error, perr_exp);
    if (stuck) check("abort_cycle", done_cyc - s3_cyc, TO + 1);
    in_frame = 1'b0;
    step();
    check("busy_after_done", bus.frame_busy, 0);
    check("oe_after_done", bus.output_enable, 0);
    repeat (3) step();
    check("single_done", done_seen, 1);
    check("busy_contiguous", busy_drop, 0);
    check("perr_held", bus.protocol_error, perr_exp);
  endtask

  task automatic reset_mid_frame();
    int budget;
    init_vars();
    directed = 1'b0; stray_mode = 1'b0; stuck_mode = 1'b0; mid_mode = 1'b0;
    step();
    bus.frame_start = 1'b1;
    bus.slice_count = CW'(2);
    budget = 0;
    while (starts[SRC_SLICE_DATA] == 0 && budget < 500) begin
      step();
      budget++;
    end
    check("rst_reached_data", starts[SRC_SLICE_DATA], 1);
    step();
    #1 reset = 1'b1;
    #1;
    check("rst_mid_oe", bus.output_enable, 0);
    check("rst_mid_val", bus.val, 0);
    check("rst_mid_size", bus.size_of_bit, 0);
    check("rst_mid_flush", bus.flush_bit, 0);
    check("rst_mid_busy", bus.frame_busy, 0);
    check("rst_mid_done", bus.frame_done, 0);
    check("rst_mid_start", bus.src_start, 0);
    check("rst_mid_fc", bus.field_count, 0);
    check("rst_mid_perr", bus.protocol_error, 0);
    bus.frame_start = 1'b0;
    bus.src_enable = '0; bus.src_done = '0; bus.src_flush = '0; bus.src_val = '0; bus.src_size = '0;
    plan.delete();
    expq.delete();
    cur_src = -1;
    repeat (3) begin
      @(negedge clock);
      check("rst_hold_done", bus.frame_done, 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    pic_v = '{64'd8, 64'd0, 64'd0, 64'd1, 64'd0, 64'd3, 64'd0};
    pic_s = '{64'd5, 64'd3, 64'd32, 64'd16, 64'd2, 64'd2, 64'd4};
    bus.frame_start = 1'b0;
    bus.slice_count = '0;
    bus.src_enable = '0; bus.src_done = '0; bus.src_flush = '0; bus.src_val = '0; bus.src_size = '0;
    init_vars();
    repeat (2) @(negedge clock);
    check("rst_oe", bus.output_enable, 0);
    check("rst_busy", bus.frame_busy, 0);
    check("rst_done", bus.frame_done, 0);
    check("rst_start", bus.src_start, 0);
    check("rst_fc", bus.field_count, 0);
    check("rst_perr", bus.protocol_error, 0);
    reset = 1'b0;

    run_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("directed_fc_held", bus.field_count, 14);
    run_frame(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_mid_frame();
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) run_frame($urandom_range(0, 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
